// File: rtl/id_ex_hazard_pipe.sv
// ID/EX, EX/MEM and MEM/WB pipeline registers with load-use stall, branch flush and global hold.
// Define HAZARD_STATS_EN to add the saturating Stall_Count / Flush_Count outputs.
module id_ex_hazard_pipe (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] ID_Rs1,
   input  logic [4:0] ID_Rs2,
   input  logic [4:0] ID_Rd,
   input  logic       ID_RegWrite,
   input  logic       ID_MemRead,
   input  logic       ID_MemWrite,
   input  logic       ID_MemtoReg,
   input  logic       ID_valid,
   input  logic       EX_BranchTaken,
   input  logic       Hold,
   output logic [4:0] EX_Rs1,
   output logic [4:0] EX_Rs2,
   output logic [4:0] EX_Rd,
   output logic       EX_RegWrite,
   output logic       EX_MemRead,
   output logic       EX_MemWrite,
   output logic       EX_MemtoReg,
   output logic       EX_valid,
   output logic [4:0] MEM_Rd,
   output logic       MEM_RegWrite,
   output logic       MEM_MemRead,
   output logic       MEM_MemWrite,
   output logic       MEM_MemtoReg,
   output logic [4:0] WB_Rd,
   output logic       WB_RegWrite,
   output logic       WB_MemtoReg,
   output logic       PC_Write,
   output logic       IF_ID_Write,
   output logic       IF_ID_Flush
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] Stall_Count,
   output logic [31:0] Flush_Count
`endif
);

   typedef enum logic [1:0] {
      ACT_ADVANCE,
      ACT_STALL,
      ACT_FLUSH,
      ACT_HOLD
   } action_t;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       valid;
   } id_ex_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       valid;
   } ex_mem_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_to_reg;
   } mem_wb_t;

   id_ex_t  id_ex_q, id_ex_d;
   ex_mem_t ex_mem_q, ex_mem_d;
   mem_wb_t mem_wb_q, mem_wb_d;
   action_t action;
   logic    load_use;

   assign load_use = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0) && ID_valid &&
                     ((id_ex_q.rd == ID_Rs1) || (id_ex_q.rd == ID_Rs2));

   always_comb begin
      if (Hold)
         action = ACT_HOLD;
      else if (EX_BranchTaken)
         action = ACT_FLUSH;
      else if (load_use)
         action = ACT_STALL;
      else
         action = ACT_ADVANCE;
   end

   // Front-end controls are forced to "advance" while reset is asserted, whatever Hold says.
   always_comb begin
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      if (rst_n) begin
         unique case (action)
            ACT_HOLD: begin
               PC_Write    = 1'b0;
               IF_ID_Write = 1'b0;
            end
            ACT_FLUSH:
               IF_ID_Flush = 1'b1;
            ACT_STALL: begin
               PC_Write    = 1'b0;
               IF_ID_Write = 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Invalid slots collapse to all-zero bubbles so nothing stale travels downstream.
   always_comb begin
      id_ex_d = '0;
      if (ID_valid) begin
         id_ex_d.rs1        = ID_Rs1;
         id_ex_d.rs2        = ID_Rs2;
         id_ex_d.rd         = ID_Rd;
         id_ex_d.reg_write  = ID_RegWrite;
         id_ex_d.mem_read   = ID_MemRead;
         id_ex_d.mem_write  = ID_MemWrite;
         id_ex_d.mem_to_reg = ID_MemtoReg;
         id_ex_d.valid      = 1'b1;
      end
   end

   always_comb begin
      ex_mem_d = '0;
      if (id_ex_q.valid) begin
         ex_mem_d.rd         = id_ex_q.rd;
         ex_mem_d.reg_write  = id_ex_q.reg_write;
         ex_mem_d.mem_read   = id_ex_q.mem_read;
         ex_mem_d.mem_write  = id_ex_q.mem_write;
         ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
         ex_mem_d.valid      = 1'b1;
      end
   end

   always_comb begin
      mem_wb_d = '0;
      if (ex_mem_q.valid) begin
         mem_wb_d.rd         = ex_mem_q.rd;
         mem_wb_d.reg_write  = ex_mem_q.reg_write;
         mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_ex_q  <= '0;
         ex_mem_q <= '0;
         mem_wb_q <= '0;
      end else begin
         unique case (action)
            ACT_HOLD: ;
            ACT_FLUSH, ACT_STALL: begin
               id_ex_q  <= '0;
               ex_mem_q <= ex_mem_d;
               mem_wb_q <= mem_wb_d;
            end
            default: begin
               id_ex_q  <= id_ex_d;
               ex_mem_q <= ex_mem_d;
               mem_wb_q <= mem_wb_d;
            end
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Stall_Count <= '0;
         Flush_Count <= '0;
      end else begin
         if (action == ACT_STALL && Stall_Count != '1)
            Stall_Count <= Stall_Count + 32'd1;
         if (action == ACT_FLUSH && Flush_Count != '1)
            Flush_Count <= Flush_Count + 32'd1;
      end
   end
`endif

   assign EX_Rs1       = id_ex_q.rs1;
   assign EX_Rs2       = id_ex_q.rs2;
   assign EX_Rd        = id_ex_q.rd;
   assign EX_RegWrite  = id_ex_q.reg_write;
   assign EX_MemRead   = id_ex_q.mem_read;
   assign EX_MemWrite  = id_ex_q.mem_write;
   assign EX_MemtoReg  = id_ex_q.mem_to_reg;
   assign EX_valid     = id_ex_q.valid;

   assign MEM_Rd       = ex_mem_q.rd;
   assign MEM_RegWrite = ex_mem_q.reg_write;
   assign MEM_MemRead  = ex_mem_q.mem_read;
   assign MEM_MemWrite = ex_mem_q.mem_write;
   assign MEM_MemtoReg = ex_mem_q.mem_to_reg;

   assign WB_Rd        = mem_wb_q.rd;
   assign WB_RegWrite  = mem_wb_q.reg_write;
   assign WB_MemtoReg  = mem_wb_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_hazard_pipe.sv
// Directed bench for id_ex_hazard_pipe: stimulus pushes hand-computed expectations, a negedge monitor pops and checks.
module tb_id_ex_hazard_pipe;

   logic       clk;
   logic       rst_n;
   logic [4:0] ID_Rs1, ID_Rs2, ID_Rd;
   logic       ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_valid;
   logic       EX_BranchTaken, Hold;
   logic [4:0] EX_Rs1, EX_Rs2, EX_Rd;
   logic       EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_valid;
   logic [4:0] MEM_Rd;
   logic       MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg;
   logic [4:0] WB_Rd;
   logic       WB_RegWrite, WB_MemtoReg;
   logic       PC_Write, IF_ID_Write, IF_ID_Flush;
`ifdef HAZARD_STATS_EN
   logic [31:0] Stall_Count, Flush_Count;
`endif

   id_ex_hazard_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_Rd(ID_Rd),
      .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
      .ID_MemWrite(ID_MemWrite), .ID_MemtoReg(ID_MemtoReg),
      .ID_valid(ID_valid), .EX_BranchTaken(EX_BranchTaken), .Hold(Hold),
      .EX_Rs1(EX_Rs1), .EX_Rs2(EX_Rs2), .EX_Rd(EX_Rd),
      .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
      .EX_MemWrite(EX_MemWrite), .EX_MemtoReg(EX_MemtoReg), .EX_valid(EX_valid),
      .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
      .MEM_MemWrite(MEM_MemWrite), .MEM_MemtoReg(MEM_MemtoReg),
      .WB_Rd(WB_Rd), .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
      .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush)
`ifdef HAZARD_STATS_EN
      , .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
`endif
   );

   typedef struct {
      int unsigned tag;
      logic [2:0]  front;   // {PC_Write, IF_ID_Write, IF_ID_Flush}
      logic [19:0] ex;      // {Rs1, Rs2, Rd, valid, RegWrite, MemRead, MemWrite, MemtoReg}
      logic [8:0]  mem;     // {Rd, RegWrite, MemRead, MemWrite, MemtoReg}
      logic [6:0]  wb;      // {Rd, RegWrite, MemtoReg}
      int unsigned sc;
      int unsigned fc;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cycle_no = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input int unsigned tag, input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL cycle %0d %s: got %h expected %h", tag, name, act, want);
      end
   endtask

   // Monitor: one expectation per cycle, sampled mid-cycle away from the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(e.tag, "front", {29'd0, PC_Write, IF_ID_Write, IF_ID_Flush}, {29'd0, e.front});
            chk(e.tag, "id_ex", {12'd0, EX_Rs1, EX_Rs2, EX_Rd, EX_valid, EX_RegWrite,
                                 EX_MemRead, EX_MemWrite, EX_MemtoReg}, {12'd0, e.ex});
            chk(e.tag, "ex_mem", {23'd0, MEM_Rd, MEM_RegWrite, MEM_MemRead, MEM_MemWrite,
                                  MEM_MemtoReg}, {23'd0, e.mem});
            chk(e.tag, "mem_wb", {25'd0, WB_Rd, WB_RegWrite, WB_MemtoReg}, {25'd0, e.wb});
`ifdef HAZARD_STATS_EN
            chk(e.tag, "stall_count", Stall_Count, e.sc);
            chk(e.tag, "flush_count", Flush_Count, e.fc);
`endif
         end
      end
   end

   // ctl = {RegWrite, MemRead, MemWrite, MemtoReg}; expectations describe outputs seen during this cycle.
   task automatic cyc(input logic rst, input logic hold, input logic br, input logic idv,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [3:0] ctl,
                      input logic pcw, input logic ifw, input logic fl,
                      input logic [4:0] ers1, input logic [4:0] ers2, input logic [4:0] erd,
                      input logic [4:0] ectl, input logic [4:0] mrd, input logic [3:0] mctl,
                      input logic [4:0] wrd, input logic [1:0] wctl,
                      input int unsigned sc, input int unsigned fc);
      exp_t e;
      rst_n          = rst;
      Hold           = hold;
      EX_BranchTaken = br;
      ID_valid       = idv;
      ID_Rs1         = rs1;
      ID_Rs2         = rs2;
      ID_Rd          = rd;
      {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg} = ctl;
      e.tag   = cycle_no;
      e.front = {pcw, ifw, fl};
      e.ex    = {ers1, ers2, erd, ectl};
      e.mem   = {mrd, mctl};
      e.wb    = {wrd, wctl};
      e.sc    = sc;
      e.fc    = fc;
      exp_q.push_back(e);
      cycle_no++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; Hold = 1'b0; EX_BranchTaken = 1'b0; ID_valid = 1'b0;
      ID_Rs1 = '0; ID_Rs2 = '0; ID_Rd = '0;
      ID_RegWrite = 1'b0; ID_MemRead = 1'b0; ID_MemWrite = 1'b0; ID_MemtoReg = 1'b0;
      @(posedge clk);
      #1;
      //  rst hld br v  rs1 rs2 rd  ctl      pcw ifw fl  ers1 ers2 erd ectl      mrd mctl     wrd wctl  sc fc
      cyc(0, 1, 1, 0,  0,  0,  0, 4'b0000,  1, 1, 0,   0,  0,  0, 5'b00000,  0, 4'b0000,  0, 2'b00, 0, 0);
      cyc(1, 0, 0, 1,  2,  3,  1, 4'b1000,  1, 1, 0,   0,  0,  0, 5'b00000,  0, 4'b0000,  0, 2'b00, 0, 0);
      cyc(1, 0, 0, 1,  4,  5,  2, 4'b1000,  1, 1, 0,   2,  3,  1, 5'b11000,  0, 4'b0000,  0, 2'b00, 0, 0);
      cyc(1, 0, 0, 1,  6,  7,  3, 4'b1000,  1, 1, 0,   4,  5,  2, 5'b11000,  1, 4'b1000,  0, 2'b00, 0, 0);
      cyc(1, 0, 0, 1,  1,  0,  5, 4'b1101,  1, 1, 0,   6,  7,  3, 5'b11000,  2, 4'b1000,  1, 2'b10, 0, 0);
      cyc(1, 0, 0, 1,  6,  5,  7, 4'b1000,  0, 0, 0,   1,  0,  5, 5'b11101,  3, 4'b1000,  2, 2'b10, 0, 0);
      cyc(1, 0, 0, 1,  6,  5,  7, 4'b1000,  1, 1, 0,   0,  0,  0, 5'b00000,  5, 4'b1101,  3, 2'b10, 1, 0);
      cyc(1, 0, 0, 1,  0,  0,  0, 4'b1101,  1, 1, 0,   6,  5,  7, 5'b11000,  0, 4'b0000,  5, 2'b11, 1, 0);
      cyc(1, 0, 0, 1,  0,  0,  9, 4'b1000,  1, 1, 0,   0,  0,  0, 5'b11101,  7, 4'b1000,  0, 2'b00, 1, 0);
      cyc(1, 0, 0, 0,  9,  9,  9, 4'b1111,  1, 1, 0,   0,  0,  9, 5'b11000,  0, 4'b1101,  7, 2'b10, 1, 0);
      cyc(1, 0, 0, 1,  1,  2,  4, 4'b1101,  1, 1, 0,   0,  0,  0, 5'b00000,  9, 4'b1000,  0, 2'b11, 1, 0);
      cyc(1, 0, 1, 1,  4,  0,  8, 4'b1000,  1, 1, 1,   1,  2,  4, 5'b11101,  0, 4'b0000,  9, 2'b10, 1, 0);
      cyc(1, 0, 0, 1,  0,  0,  6, 4'b1101,  1, 1, 0,   0,  0,  0, 5'b00000,  4, 4'b1101,  0, 2'b00, 1, 1);
      cyc(1, 1, 0, 1,  6,  1, 10, 4'b1000,  0, 0, 0,   0,  0,  6, 5'b11101,  0, 4'b0000,  4, 2'b11, 1, 1);
      cyc(1, 1, 0, 1,  6,  1, 10, 4'b1000,  0, 0, 0,   0,  0,  6, 5'b11101,  0, 4'b0000,  4, 2'b11, 1, 1);
      cyc(1, 1, 1, 1,  6,  1, 10, 4'b1000,  0, 0, 0,   0,  0,  6, 5'b11101,  0, 4'b0000,  4, 2'b11, 1, 1);
      cyc(1, 0, 0, 1,  6,  1, 10, 4'b1000,  0, 0, 0,   0,  0,  6, 5'b11101,  0, 4'b0000,  4, 2'b11, 1, 1);
      cyc(1, 0, 0, 1,  6,  1, 10, 4'b1000,  1, 1, 0,   0,  0,  0, 5'b00000,  6, 4'b1101,  0, 2'b00, 2, 1);
      cyc(1, 0, 0, 1,  2,  3,  0, 4'b0010,  1, 1, 0,   6,  1, 10, 5'b11000,  0, 4'b0000,  6, 2'b11, 2, 1);
      cyc(1, 0, 0, 0,  0,  0,  0, 4'b0000,  1, 1, 0,   2,  3,  0, 5'b10010, 10, 4'b1000,  0, 2'b00, 2, 1);
      cyc(1, 1, 0, 0,  0,  0,  0, 4'b0000,  0, 0, 0,   0,  0,  0, 5'b00000,  0, 4'b0010, 10, 2'b10, 2, 1);
      cyc(0, 1, 1, 0,  0,  0,  0, 4'b0000,  1, 1, 0,   0,  0,  0, 5'b00000,  0, 4'b0000,  0, 2'b00, 0, 0);
      cyc(1, 0, 0, 1,  0,  0,  3, 4'b1101,  1, 1, 0,   0,  0,  0, 5'b00000,  0, 4'b0000,  0, 2'b00, 0, 0);
      cyc(0, 0, 0, 1,  3,  0, 12, 4'b1000,  1, 1, 0,   0,  0,  0, 5'b00000,  0, 4'b0000,  0, 2'b00, 0, 0);
      cyc(1, 0, 0, 1,  3,  0, 12, 4'b1000,  1, 1, 0,   0,  0,  0, 5'b00000,  0, 4'b0000,  0, 2'b00, 0, 0);
      cyc(1, 0, 0, 0,  0,  0,  0, 4'b0000,  1, 1, 0,   3,  0, 12, 5'b11000,  0, 4'b0000,  0, 2'b00, 0, 0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/id_ex_hazard_pipe.md
ID_EX_HAZARD_PIPE -- requirements
Module: id_ex_hazard_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ID_Rs1, ID_Rs2, ID_Rd  input  5 each  register indices of the instruction in decode.
REQ-005 ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg  input  1 each  decode control bits.
REQ-006 ID_valid  input  1  decode slot holds a real instruction.
REQ-007 EX_BranchTaken  input  1  branch/jump resolved taken in EX this cycle.
REQ-008 Hold  input  1  global freeze (memory wait); all state holds.
REQ-009 EX_Rs1, EX_Rs2, EX_Rd  output  5 each  ID/EX register indices, consumed by the forwarding unit.
REQ-010 EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_valid  output  1 each  ID/EX controls.
REQ-011 MEM_Rd  output  5; MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg  output  1 each  EX/MEM register.
REQ-012 WB_Rd  output  5; WB_RegWrite, WB_MemtoReg  output  1 each  MEM/WB register.
REQ-013 PC_Write, IF_ID_Write  output  1 each  low = front end holds.
REQ-014 IF_ID_Flush  output  1  high = IF/ID becomes a bubble at next edge.
REQ-015 Stall_Count, Flush_Count  output  32 each  present only with HAZARD_STATS_EN.

Function
REQ-016 load_use SHALL be EX_valid & EX_MemRead & (EX_Rd != 0) & ID_valid & ((EX_Rd == ID_Rs1) | (EX_Rd == ID_Rs2)), combinational.
REQ-017 Priority SHALL be Hold > EX_BranchTaken > load_use > normal advance.
REQ-018 Hold=1: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, every register unchanged, counters unchanged.
REQ-019 Flush (Hold=0, EX_BranchTaken=1): IF_ID_Flush=1, PC_Write=1, IF_ID_Write=1, ID/EX loads a bubble, EX/MEM and MEM/WB advance.
REQ-020 Stall (Hold=0, EX_BranchTaken=0, load_use=1): PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, ID/EX loads a bubble, EX/MEM and MEM/WB advance.
REQ-021 Normal: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID/EX <= ID inputs, EX/MEM <= ID/EX, MEM/WB <= EX/MEM.
REQ-022 A bubble SHALL be all control bits 0, valid 0, Rs1/Rs2/Rd 0.
REQ-023 ID inputs with ID_valid=0 SHALL load ID/EX as a bubble (controls gated by valid).
REQ-024 EX/MEM and MEM/WB SHALL carry only valid instructions' controls; a bubble stays a bubble downstream.
REQ-025 Latency SHALL be exactly one cycle per stage; no combinational path from ID inputs to any EX/MEM/WB output.
REQ-026 Load-use SHALL stall exactly one cycle: after the bubble, EX_MemRead=0, so load_use deasserts.
REQ-027 Branch taken and load_use in the same cycle: flush wins, no stall, Stall_Count unchanged.

Reset
REQ-028 rst_n low SHALL immediately clear all pipeline registers to bubbles, counters to 0.
REQ-029 During reset PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0.
REQ-030 Reset asserted mid-stall or mid-hold SHALL abort it; first edge after release is a normal advance.

Configuration
REQ-031 HAZARD_STATS_EN defined: Stall_Count increments on each REQ-020 cycle, Flush_Count on each REQ-019 cycle, both saturate at 32'hFFFFFFFF, no increment under Hold.
REQ-032 HAZARD_STATS_EN undefined: Stall_Count, Flush_Count ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-033 lw x5 in EX (EX_Rd=5, EX_MemRead=1), ID_Rs2=5 -> PC_Write=0, IF_ID_Write=0 one cycle; next cycle EX_valid=0, MEM_Rd=5, MEM_MemRead=1; Stall_Count=1.
REQ-034 EX_Rd=0 load, ID_Rs1=0 -> no stall, PC_Write=1.
REQ-035 EX_BranchTaken=1 with load_use true -> IF_ID_Flush=1, PC_Write=1; next cycle EX_valid=0; Flush_Count=1, Stall_Count=0.
REQ-036 Hold=1 for 3 cycles during a stall -> all outputs frozen, counters frozen; release -> stall completes in one cycle.
REQ-037 Back-to-back add x1/add x2/add x3 -> Rd 1,2,3 appear on EX_Rd, MEM_Rd, WB_Rd in consecutive cycles, no stall.
REQ-038 rst_n low mid-pipeline with WB_RegWrite=1 -> WB_RegWrite=0 before next clock edge.
